// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between the execute stage and the iterative RV32M
// multiply/divide unit.
//   Start    : request. The unit samples it only when it is idle or in DONE.
//   Funct3   : operation select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   SrcA     : rs1 operand (multiplicand / dividend)
//   SrcB     : rs2 operand (multiplier / divisor)
//   Kill     : synchronous abort (pipeline flush)
//   Busy     : an operation occupies the unit
//   Done     : one-cycle pulse, MDResult is valid
//   MDResult : registered result, holds until the next completion
// Modports: master = execute stage / requester, slave = the unit.
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Start;
   logic [2:0]            Funct3;
   logic [DATA_WIDTH-1:0] SrcA;
   logic [DATA_WIDTH-1:0] SrcB;
   logic                  Kill;
   logic                  Busy;
   logic                  Done;
   logic [DATA_WIDTH-1:0] MDResult;

   modport master (
      output Start, Funct3, SrcA, SrcB, Kill,
      input  Busy, Done, MDResult
   );

   modport slave (
      input  Start, Funct3, SrcA, SrcB, Kill,
      output Busy, Done, MDResult
   );
endinterface

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes on
// acceptance, processed one bit per cycle (shift-add multiply or restoring
// divide) for DATA_WIDTH cycles, then sign-corrected in a single FIX cycle.
// Latency from accepted Start to Done is a fixed DATA_WIDTH+1 cycles.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_div_unit_if slave modport (Start/Funct3/SrcA/SrcB/Kill in,
//           Busy/Done/MDResult out)
// -----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  bus
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       funct3_reg;
   // Multiply: multiplicand magnitude. Divide: divisor magnitude.
   logic [W-1:0]     opnd_reg;
   // Multiply: {partial product high, multiplier shifting out / product low}.
   // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
   logic [2*W-1:0]   acc_reg;
   logic [W-1:0]     src_a_reg;
   logic             neg_a_reg;
   logic             neg_b_reg;
   logic             div_zero_reg;
   logic             ovf_reg;
   logic [W-1:0]     md_result_reg;

   // ---------------------------------------------------------------------------
   // Request decode (used only on the accepting edge)
   // ---------------------------------------------------------------------------
   logic         start_ok;
   logic         is_div_req;
   logic         a_signed_req;
   logic         b_signed_req;
   logic         a_neg_req;
   logic         b_neg_req;
   logic [W-1:0] a_mag_req;
   logic [W-1:0] b_mag_req;
   logic         div_zero_req;
   logic         ovf_req;

   always_comb begin
      start_ok = bus.Start && !bus.Kill &&
                 ((state_reg == IDLE) || (state_reg == DONE));

      is_div_req = bus.Funct3[2];

      a_signed_req = 1'b0;
      b_signed_req = 1'b0;
      unique case (bus.Funct3)
         F_MUL, F_MULH, F_DIV, F_REM: begin
            a_signed_req = 1'b1;
            b_signed_req = 1'b1;
         end
         F_MULHSU: begin
            a_signed_req = 1'b1;
            b_signed_req = 1'b0;
         end
         F_MULHU, F_DIVU, F_REMU: begin
            a_signed_req = 1'b0;
            b_signed_req = 1'b0;
         end
         default: begin
            a_signed_req = 1'b0;
            b_signed_req = 1'b0;
         end
      endcase

      a_neg_req = a_signed_req && bus.SrcA[W-1];
      b_neg_req = b_signed_req && bus.SrcB[W-1];

      // The most negative value maps to itself, which read as unsigned is the
      // correct magnitude 2^(W-1).
      a_mag_req = a_neg_req ? (-bus.SrcA) : bus.SrcA;
      b_mag_req = b_neg_req ? (-bus.SrcB) : bus.SrcB;

      div_zero_req = is_div_req && (bus.SrcB == '0);
      ovf_req      = ((bus.Funct3 == F_DIV) || (bus.Funct3 == F_REM)) &&
                     (bus.SrcA == MIN_NEG) && (bus.SrcB == ALL_ONES);
   end

   // ---------------------------------------------------------------------------
   // One iteration step
   // ---------------------------------------------------------------------------
   logic [W:0]     mul_sum;
   logic [W:0]     div_partial;
   logic           div_ge;
   logic [W-1:0]   div_diff;
   logic [2*W-1:0] acc_step;

   always_comb begin
      // Shift-add: conditionally add the multiplicand into the high half, then
      // shift the whole accumulator right; the carry lands in the top bit.
      mul_sum = {1'b0, acc_reg[2*W-1:W]} +
                (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});

      // Restoring divide: bring the next dividend bit into the remainder and
      // keep the difference only if it did not go negative.
      div_partial = {acc_reg[2*W-1:W], acc_reg[W-1]};
      div_ge      = (div_partial >= {1'b0, opnd_reg});
      // When div_ge holds the difference is below the divisor, so W bits suffice.
      div_diff    = div_partial[W-1:0] - opnd_reg;

      if (funct3_reg[2]) begin
         if (div_ge) begin
            acc_step = {div_diff, acc_reg[W-2:0], 1'b1};
         end else begin
            acc_step = {div_partial[W-1:0], acc_reg[W-2:0], 1'b0};
         end
      end else begin
         acc_step = {mul_sum, acc_reg[W-1:1]};
      end
   end

   // ---------------------------------------------------------------------------
   // Sign correction and special-case override (evaluated in FIX)
   // ---------------------------------------------------------------------------
   logic [2*W-1:0] product;
   logic [W-1:0]   quot;
   logic [W-1:0]   rem;
   logic [W-1:0]   fix_result;

   always_comb begin
      product = (neg_a_reg ^ neg_b_reg) ? (-acc_reg) : acc_reg;
      quot    = (neg_a_reg ^ neg_b_reg) ? (-acc_reg[W-1:0]) : acc_reg[W-1:0];
      rem     = neg_a_reg ? (-acc_reg[2*W-1:W]) : acc_reg[2*W-1:W];

      if (div_zero_reg) begin
         quot = ALL_ONES;
         rem  = src_a_reg;
      end else if (ovf_reg) begin
         quot = MIN_NEG;
         rem  = '0;
      end

      unique case (funct3_reg)
         F_MUL:                      fix_result = product[W-1:0];
         F_MULH, F_MULHSU, F_MULHU:  fix_result = product[2*W-1:W];
         F_DIV, F_DIVU:              fix_result = quot;
         F_REM, F_REMU:              fix_result = rem;
         default:                    fix_result = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (bus.Kill) begin
         // Flush wins over everything, including a simultaneous Start.
         state_next = IDLE;
      end else begin
         unique case (state_reg)
            IDLE: if (bus.Start) state_next = CALC;
            CALC: if (cnt_reg == LAST_CNT) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = bus.Start ? CALC : IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         funct3_reg    <= '0;
         opnd_reg      <= '0;
         acc_reg       <= '0;
         src_a_reg     <= '0;
         neg_a_reg     <= 1'b0;
         neg_b_reg     <= 1'b0;
         div_zero_reg  <= 1'b0;
         ovf_reg       <= 1'b0;
         md_result_reg <= '0;
      end else begin
         state_reg <= state_next;

         if (start_ok) begin
            funct3_reg   <= bus.Funct3;
            cnt_reg      <= '0;
            src_a_reg    <= bus.SrcA;
            neg_a_reg    <= a_neg_req;
            neg_b_reg    <= b_neg_req;
            div_zero_reg <= div_zero_req;
            ovf_reg      <= ovf_req;
            if (is_div_req) begin
               opnd_reg <= b_mag_req;
               acc_reg  <= {{W{1'b0}}, a_mag_req};
            end else begin
               opnd_reg <= a_mag_req;
               acc_reg  <= {{W{1'b0}}, b_mag_req};
            end
         end else if ((state_reg == CALC) && !bus.Kill) begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg + CNT_W'(1);
         end

         // A flush during FIX discards the result; MDResult keeps its old value.
         if ((state_reg == FIX) && !bus.Kill) begin
            md_result_reg <= fix_result;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: all derived from registers only
   // ---------------------------------------------------------------------------
   assign bus.Busy     = (state_reg == CALC) || (state_reg == FIX);
   assign bus.Done     = (state_reg == DONE);
   assign bus.MDResult = md_result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Self-checking bench for mul_div_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written sequences
// for reset, kill and start handshaking.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam int DW = 32;
   localparam int LAT = DW + 1;

   logic clk;
   logic rst_n;

   mul_div_unit_if #(.DATA_WIDTH(DW)) bus ();

   mul_div_unit #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: plain wide arithmetic on the architectural definitions.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0]        as64, au64, bs64, bu64, p;
      logic signed [31:0] sa, sb;
      logic [31:0]        r;
      as64 = {{32{a[31]}}, a};
      au64 = {32'd0, a};
      bs64 = {{32{b[31]}}, b};
      bu64 = {32'd0, b};
      sa = a;
      sb = b;
      r = '0;
      case (f)
         3'd0: begin p = as64 * bs64; r = p[31:0];  end
         3'd1: begin p = as64 * bs64; r = p[63:32]; end
         3'd2: begin p = as64 * bu64; r = p[63:32]; end
         3'd3: begin p = au64 * bu64; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = sa / sb;
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = sa % sb;
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rand_opnd();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = 32'($urandom_range(0, 15));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issue one operation, scramble the inputs right after acceptance, and wait
   // (bounded) for Done. lat = number of edges from acceptance to Done, 0 on timeout.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      bus.Start  = 1'b1;
      bus.Funct3 = f;
      bus.SrcA   = a;
      bus.SrcB   = b;
      @(posedge clk);
      #1;
      bus.Start  = 1'b0;
      bus.SrcA   = $urandom;
      bus.SrcB   = $urandom;
      bus.Funct3 = 3'($urandom);
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (bus.Done) begin
            lat = n;
            break;
         end
      end
      res = bus.MDResult;
      $display("op f=%0d a=0x%08h b=0x%08h -> 0x%08h latency=%0d", f, a, b, res, lat);
   endtask

   logic [31:0] res, res2, prev, exp;
   int          lat, lat2, done_seen;
   logic [2:0]  rf;
   logic [31:0] ra, rb;

   initial begin
      vecs[0]  = '{"mul_7_x_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{"mulh_min_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{"mulhu_ones",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{"mulhsu_ones",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{"div_m7_2",       3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      vecs[5]  = '{"rem_m7_2",       3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      vecs[6]  = '{"divu_100_7",     3'd5, 32'd100,        32'd7,         32'd14};
      vecs[7]  = '{"remu_100_7",     3'd7, 32'd100,        32'd7,         32'd2};
      vecs[8]  = '{"divu_5_0",       3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
      vecs[9]  = '{"remu_5_0",       3'd7, 32'd5,          32'd0,         32'd5};
      vecs[10] = '{"div_ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{"rem_ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

      rst_n      = 1'b0;
      bus.Start  = 1'b0;
      bus.Kill   = 1'b0;
      bus.Funct3 = 3'd0;
      bus.SrcA   = '0;
      bus.SrcB   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   32'(bus.Busy), 32'd0);
      check("reset_done",   32'(bus.Done), 32'd0);
      check("reset_result", bus.MDResult, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
         check({vecs[i].name, "_result"}, res, vecs[i].exp);
         check({vecs[i].name, "_latency"}, 32'(lat), 32'(LAT));
         @(posedge clk);
         #1;
         check({vecs[i].name, "_done_pulse"}, 32'(bus.Done), 32'd0);
         check({vecs[i].name, "_idle_after"}, 32'(bus.Busy), 32'd0);
      end

      // Randomized operations against the model
      for (int i = 0; i < 60; i++) begin
         rf = 3'($urandom);
         ra = rand_opnd();
         rb = rand_opnd();
         run_op(rf, ra, rb, res, lat);
         check("rand_result", res, model(rf, ra, rb));
         check("rand_latency", 32'(lat), 32'(LAT));
      end

      // Kill at cycle 10 of CALC
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, prev, lat);
      @(negedge clk);
      bus.Start = 1'b1; bus.Funct3 = 3'd5; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.Kill = 1'b1;
      @(posedge clk);
      #1;
      bus.Kill = 1'b0;
      check("kill_busy_low", 32'(bus.Busy), 32'd0);
      check("kill_done_low", 32'(bus.Done), 32'd0);
      done_seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.Done || bus.Busy) done_seen++;
      end
      check("kill_no_done", 32'(done_seen), 32'd0);
      check("kill_result_held", bus.MDResult, prev);
      $display("kill mid-calc: result held 0x%08h", bus.MDResult);

      // Start together with Kill in IDLE is not accepted
      @(negedge clk);
      bus.Start = 1'b1; bus.Kill = 1'b1;
      @(posedge clk);
      #1;
      check("start_kill_idle_busy", 32'(bus.Busy), 32'd0);
      @(negedge clk);
      bus.Start = 1'b0; bus.Kill = 1'b0;
      @(posedge clk);
      #1;
      check("start_kill_idle_busy2", 32'(bus.Busy), 32'd0);
      $display("start+kill in idle: busy=%0d", bus.Busy);

      // Start pulsed while busy is ignored
      @(negedge clk);
      bus.Start = 1'b1; bus.Funct3 = 3'd0; bus.SrcA = 32'd7; bus.SrcB = 32'hFFFF_FFFD;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      lat = 0;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (n == 5) begin
            bus.Start = 1'b1; bus.Funct3 = 3'd5; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
         end else if (n == 6) begin
            bus.Start = 1'b0;
         end
         if (bus.Done) begin
            lat = n;
            break;
         end
      end
      check("busy_start_result", bus.MDResult, 32'hFFFF_FFEB);
      check("busy_start_latency", 32'(lat), 32'(LAT));
      @(posedge clk);
      #1;
      check("busy_start_no_restart", 32'(bus.Busy), 32'd0);
      $display("start during busy: result 0x%08h latency=%0d", bus.MDResult, lat);

      // Start held during DONE: back-to-back
      run_op(3'd5, 32'd100, 32'd7, res, lat);
      check("b2b_first_result", res, 32'd14);
      check("b2b_first_latency", 32'(lat), 32'(LAT));
      bus.Start = 1'b1; bus.Funct3 = 3'd6; bus.SrcA = 32'hFFFF_FFF9; bus.SrcB = 32'd2;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.SrcA = $urandom;
      check("b2b_accept_busy", 32'(bus.Busy), 32'd1);
      check("b2b_result_held", bus.MDResult, 32'd14);
      lat2 = 0;
      for (int n = 2; n <= 100; n++) begin
         @(posedge clk);
         #1;
         if (bus.Done) begin
            lat2 = n;
            break;
         end
      end
      res2 = bus.MDResult;
      exp = model(3'd6, 32'hFFFF_FFF9, 32'd2);
      check("b2b_second_result", res2, exp);
      check("b2b_done_spacing", 32'(lat2), 32'(LAT + 1));
      $display("back-to-back: 0x%08h then 0x%08h spacing=%0d", res, res2, lat2);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      bus.Start = 1'b1; bus.Funct3 = 3'd0; bus.SrcA = 32'd3; bus.SrcB = 32'd5;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy",   32'(bus.Busy), 32'd0);
      check("rst_mid_done",   32'(bus.Done), 32'd0);
      check("rst_mid_result", bus.MDResult, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.Busy || bus.Done) done_seen++;
      end
      check("rst_release_idle", 32'(done_seen), 32'd0);
      $display("reset mid-calc: busy=%0d done=%0d result=0x%08h", bus.Busy, bus.Done, bus.MDResult);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same register operands (SrcA, SrcB) and the instruction's funct3, and produces a 32-bit result after a fixed multi-cycle latency. The execute-stage result mux selects its output in place of ALUResult. Busy stalls the upstream pipeline while an operation is in flight.

## Interface
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only when the unit is idle or in DONE
- Funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  DATA_WIDTH  rs1 operand (multiplicand / dividend)
- SrcB  in  DATA_WIDTH  rs2 operand (multiplier / divisor)
- Kill  in  1  synchronous abort (pipeline flush)
- Busy  out  1  high while an operation occupies the unit
- Done  out  1  one-cycle pulse: Result is valid
- MDResult  out  DATA_WIDTH  registered result; holds until the next completion

## Operation
- States:
  - IDLE → CALC on Start, when Kill is low.
  - CALC runs DATA_WIDTH iterations, then goes to FIX.
  - FIX → DONE.
  - DONE → IDLE, or → CALC if Start is asserted and Kill is low.
- Busy = (state is CALC or FIX). Done = (state is DONE).
- On accepted Start:
  - Latch Funct3.
  - Latch the operand magnitudes, the sign flags and the special-case flags.
  - Clear the iteration counter.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV and REM: both signed.
- Multiply:
  - Shift-add of magnitudes into a 2·DATA_WIDTH accumulator, one multiplier bit per CALC cycle.
  - FIX negates the product when the operand signs differ.
  - MUL returns the low half; the other multiply ops return the high half.
- Divide:
  - Restoring division of magnitudes, one quotient bit per CALC cycle.
  - FIX negates the quotient when the signs differ.
  - FIX negates the remainder when the dividend is negative.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide by zero (SrcB == 0):
  - Quotient = all ones.
  - Remainder = SrcA unmodified.
- Signed overflow (DIV/REM with SrcA = 0x80000000 and SrcB = 0xFFFFFFFF):
  - Quotient = 0x80000000.
  - Remainder = 0.
- Special cases keep the full latency; FIX overrides the result.
- Start while Busy is ignored and has no side effects.
- Kill in any state:
  - Next edge → IDLE; Busy and Done low.
  - MDResult unchanged.
  - Kill overrides a simultaneous Start.
- Operands are latched, so SrcA, SrcB and Funct3 may change after Start is accepted.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, Busy 0, Done 0, MDResult 0, counter 0, internal registers 0.
- Reset asserted mid-operation aborts immediately; there is no Done.
- Start accepted at edge E0:
  - Busy high from E0 through E0+DATA_WIDTH+1 (33 cycles for width 32).
  - At E0+DATA_WIDTH+1, MDResult updates and Done goes high for exactly one cycle.
  - Done drops at E0+DATA_WIDTH+2, unless Start was asserted during DONE.
  - Latency is fixed at DATA_WIDTH+1 cycles, independent of operation or data.
- Back-to-back: Start asserted during DONE is accepted at that edge. Throughput is one result per DATA_WIDTH+2 cycles.
- Done and MDResult are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst_n low mid-CALC → Busy, Done and MDResult go to 0 immediately; after release, Busy stays 0 until the next Start.
- Multiply checks:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, Done exactly 33 cycles after Start.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide checks:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - All with 33-cycle latency.
- Kill:
  - Kill at cycle 10 of CALC → Busy low next cycle, no Done, MDResult keeps the previous value.
  - Start with Kill in IDLE → not accepted.
- Handshake:
  - Start pulsed during Busy → ignored, result matches the first operation.
  - Start held during DONE → new operation accepted, second Done 34 cycles after the first, correct results for both.
